// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered 4:1 data mux among four requesters, with a valid/ready output slot.
// Optional burst lock is compiled in with `define MUX_RR_ARBITER_LOCK_EN.
module mux_rr_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    input  logic [3:0]    lock,
    output logic [3:0]    gnt,
    output logic          sel1,
    output logic          sel0,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    // Handshake: a word moves to the consumer on any rising edge where
    // out_valid && out_ready; out_data and sel stay stable while out_valid && !out_ready.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t         state;
    logic [1:0]    last;
    logic [1:0]    rr_winner;
    logic [1:0]    winner;
    logic [1:0]    scan_idx;
    logic          found;
    logic          load;
    logic [DW-1:0] mux_data;

    assign out_valid = (state == FULL);
    assign load      = !rst && (req != 4'b0000) && (!out_valid || out_ready);

    // Scan upward from the requester after the last winner, wrapping at 3.
    always_comb begin
        rr_winner = last;
        found     = 1'b0;
        scan_idx  = last;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last + 2'(k);
            if (!found && req[scan_idx]) begin
                rr_winner = scan_idx;
                found     = 1'b1;
            end
        end
    end

`ifdef MUX_RR_ARBITER_LOCK_EN
    logic lock_q;
    logic lock_hold;

    // The previous winner keeps the slot while it still requests and still asserts lock.
    assign lock_hold = lock_q && req[last] && lock[last];
    assign winner    = lock_hold ? last : rr_winner;
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign winner      = rr_winner;
`endif

    assign gnt = load ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        mux_data = d0;
        case (winner)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            sel1     <= 1'b0;
            sel0     <= 1'b0;
            last     <= 2'd3;
`ifdef MUX_RR_ARBITER_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else if (load) begin
            state        <= FULL;
            out_data     <= mux_data;
            {sel1, sel0} <= winner;
            last         <= winner;
`ifdef MUX_RR_ARBITER_LOCK_EN
            lock_q       <= lock[winner];
`endif
        end else if (out_valid && out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, stall, sparse requests, reset mid-stall, lock.
// Expected values are hand-computed; lock expectations follow MUX_RR_ARBITER_LOCK_EN.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       sel1, sel0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    int total;
    int bad;

    mux_rr_arbiter #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .lock      (lock),
        .gnt       (gnt),
        .sel1      (sel1),
        .sel0      (sel0),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check gnt before the edge, then the registered slot just after it.
    task automatic step(input logic [3:0] eg, input logic ev, input logic [7:0] ed, input logic [1:0] es);
        #1;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data", 32'(out_data), 32'(ed));
        chk("sel", 32'({sel1, sel0}), 32'(es));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req       = 4'b1111;
        lock      = 4'b0000;
        d0        = 8'h10;
        d1        = 8'h11;
        d2        = 8'h12;
        d3        = 8'h13;
        out_ready = 1'b1;

        // Held in reset with every requester active.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'({sel1, sel0}), 32'h0);
        rst = 1'b0;

        // Full rotation, then continue around to requester 2.
        step(4'b0001, 1'b1, 8'h10, 2'd0);
        step(4'b0010, 1'b1, 8'h11, 2'd1);
        step(4'b0100, 1'b1, 8'h12, 2'd2);
        step(4'b1000, 1'b1, 8'h13, 2'd3);
        step(4'b0001, 1'b1, 8'h10, 2'd0);
        step(4'b0010, 1'b1, 8'h11, 2'd1);
        step(4'b0100, 1'b1, 8'h12, 2'd2);

        // Stall with the slot full of 8'h12.
        out_ready = 1'b0;
        req       = 4'b1011;
        step(4'b0000, 1'b1, 8'h12, 2'd2);
        step(4'b0000, 1'b1, 8'h12, 2'd2);
        step(4'b0000, 1'b1, 8'h12, 2'd2);
        out_ready = 1'b1;
        step(4'b1000, 1'b1, 8'h13, 2'd3);

        // Sparse rotation: 0, then 2,0, pulse on 1, then 2.
        req = 4'b0101;
        step(4'b0001, 1'b1, 8'h10, 2'd0);
        step(4'b0100, 1'b1, 8'h12, 2'd2);
        step(4'b0001, 1'b1, 8'h10, 2'd0);
        req = 4'b0111;
        step(4'b0010, 1'b1, 8'h11, 2'd1);
        req = 4'b0101;
        step(4'b0100, 1'b1, 8'h12, 2'd2);

        // Drain: slot empties, data and sel hold.
        req = 4'b0000;
        step(4'b0000, 1'b0, 8'h12, 2'd2);
        step(4'b0000, 1'b0, 8'h12, 2'd2);

        // Fill then stall, and assert reset mid-cycle.
        req       = 4'b0001;
        out_ready = 1'b0;
        step(4'b0001, 1'b1, 8'h10, 2'd0);
        step(4'b0000, 1'b1, 8'h10, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_sel", 32'({sel1, sel0}), 32'h0);
        chk("arst_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        step(4'b0001, 1'b1, 8'h10, 2'd0);

        // Lock on requester 1 for three loads, then release.
        req  = 4'b0011;
        lock = 4'b0010;
        step(4'b0010, 1'b1, 8'h11, 2'd1);
`ifdef MUX_RR_ARBITER_LOCK_EN
        step(4'b0010, 1'b1, 8'h11, 2'd1);
        step(4'b0010, 1'b1, 8'h11, 2'd1);
`else
        step(4'b0001, 1'b1, 8'h10, 2'd0);
        step(4'b0010, 1'b1, 8'h11, 2'd1);
`endif
        lock = 4'b0000;
        step(4'b0001, 1'b1, 8'h10, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
